icache_prefetch_buffer: RTL and testbench

Next-line instruction prefetcher between the I-cache's memory port and slow_memI. It forwards demand line reads and writes from the cache to slow memory. After every demand read it fetches the following 128-bit line into a one-entry stream buffer, so a sequential miss to that line is answered in one cycle instead of a full slow-memory round trip. Both faces of the block use the existing line-memory handshake, so it drops into the top level with no change to the cache.

---
 rtl/icache_prefetch_buffer.sv | 199 +++++++++++++++++++
 tb/tb_icache_prefetch_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_prefetch_buffer.sv
// Next-line prefetcher between the I-cache line port and slow memory.
// Define ICACHE_PREFETCH_EN to enable the one-entry stream buffer.
module icache_prefetch_buffer #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [LINE_W-1:0] cache_wdata,
    output logic [LINE_W-1:0] cache_rdata,
    output logic              cache_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       pf_hits
);
    typedef enum logic [2:0] {
        IDLE, DEMAND, WRITE, RESP, PREFETCH
    } state_e;

    state_e            state_q, state_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              mrd_q, mrd_d;
    logic              mwr_q, mwr_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [LINE_W-1:0] mwdata_q, mwdata_d;
    logic              hit;
    logic [LINE_W-1:0] hit_data;

`ifdef ICACHE_PREFETCH_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [LINE_W-1:0] buf_data_q, buf_data_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic [15:0]       hits_q, hits_d;
    logic              rd_q, rd_d;

    assign hit      = buf_valid_q && (buf_addr_q == cache_addr);
    assign hit_data = buf_data_q;
    assign pf_hits  = hits_q;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            pf_addr_q   <= '0;
            hits_q      <= '0;
            rd_q        <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            pf_addr_q   <= pf_addr_d;
            hits_q      <= hits_d;
            rd_q        <= rd_d;
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        pf_addr_d   = pf_addr_q;
        hits_d      = hits_q;
        rd_d        = rd_q;
        unique case (state_q)
            IDLE: begin
                if (cache_write) begin
                    rd_d = 1'b0;
                    if (buf_addr_q == cache_addr) buf_valid_d = 1'b0;
                end else if (cache_read && hit) begin
                    rd_d        = 1'b1;
                    buf_valid_d = 1'b0;
                    pf_addr_d   = cache_addr + ADDR_W'(1);
                    if (hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
                end else if (cache_read) begin
                    rd_d = 1'b1;
                end
            end
            DEMAND: begin
                if (mem_ready) pf_addr_d = maddr_q + ADDR_W'(1);
            end
            PREFETCH: begin
                // a write to the line being fetched leaves it stale
                if (mem_ready) begin
                    buf_data_d  = mem_rdata;
                    buf_addr_d  = pf_addr_q;
                    buf_valid_d = !(cache_write && cache_addr == pf_addr_q);
                end
            end
            default: ;
        endcase
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
    assign pf_hits  = '0;
`endif

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        unique case (state_q)
            IDLE: begin
                if (cache_write) begin
                    state_d  = WRITE;
                    mwr_d    = 1'b1;
                    maddr_d  = cache_addr;
                    mwdata_d = cache_wdata;
                end else if (cache_read && hit) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    rdata_d = hit_data;
                end else if (cache_read) begin
                    state_d = DEMAND;
                    mrd_d   = 1'b1;
                    maddr_d = cache_addr;
                end
            end
            DEMAND: begin
                if (mem_ready) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    mrd_d   = 1'b0;
                    rdata_d = mem_rdata;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    mwr_d   = 1'b0;
                end
            end
            RESP: begin
`ifdef ICACHE_PREFETCH_EN
                if (rd_q) begin
                    state_d = PREFETCH;
                    mrd_d   = 1'b1;
                    maddr_d = pf_addr_q;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
`ifdef ICACHE_PREFETCH_EN
            PREFETCH: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    mrd_d   = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign cache_rdata = rdata_q;
    assign cache_ready = ready_q;
    assign mem_read    = mrd_q;
    assign mem_write   = mwr_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = mwdata_q;
endmodule

// File: tb/tb_icache_prefetch_buffer.sv
// Bench for icache_prefetch_buffer: transaction model of the stream
// buffer plus a slow-memory responder; works with or without prefetch.
module tb_icache_prefetch_buffer;
`ifdef ICACHE_PREFETCH_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    typedef struct packed {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } req_t;

    logic         clk = 1'b0;
    logic         proc_reset = 1'b1;
    logic         cache_read = 1'b0;
    logic         cache_write = 1'b0;
    logic [27:0]  cache_addr = '0;
    logic [127:0] cache_wdata = '0;
    logic [127:0] cache_rdata;
    logic         cache_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [15:0]  pf_hits;

    int vectors = 0;
    int miscompares = 0;

    icache_prefetch_buffer dut (
        .clk(clk), .proc_reset(proc_reset),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata), .cache_ready(cache_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pf_hits(pf_hits)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] dflt(input logic [27:0] a);
        return {4'h1, a, 4'h2, ~a, 4'h3, a ^ 28'h5A5A5A5, 4'h4, a + 28'd77};
    endfunction

    // slow memory: fixed latency per request, logs every request
    int           mem_lat = 3;
    int           cnt = 0;
    int           cur_lat = 1;
    bit           busy = 1'b0;
    req_t         got[$];
    req_t         exp_q[$];
    logic [127:0] mem_img [logic [27:0]];

    always begin
        req_t r;
        @(posedge clk);
        #1;
        if (proc_reset) begin
            cnt = 0; busy = 1'b0; mem_ready = 1'b0;
        end else if (mem_ready) begin
            mem_ready = 1'b0; busy = 1'b0; cnt = 0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end else if (mem_read || mem_write) begin
            if (!busy) begin
                busy = 1'b1; cur_lat = mem_lat; cnt = 0;
                r.wr = mem_write;
                r.addr = mem_addr;
                r.wdata = mem_write ? mem_wdata : '0;
                got.push_back(r);
                vectors++;
                if (mem_read && mem_write) begin
                    miscompares++;
                    $display("FAIL rd_wr_excl: mem_read=%0b mem_write=%0b, need not both", mem_read, mem_write);
                end
            end
            cnt++;
            if (cnt >= cur_lat) begin
                mem_ready = 1'b1;
                if (mem_write) mem_img[mem_addr] = mem_wdata;
                else mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : dflt(mem_addr);
            end
        end
    end

    // behavioural model of the stream buffer
    logic [127:0] mdl_mem [logic [27:0]];
    bit           mdl_valid = 1'b0;
    logic [27:0]  mdl_baddr = '0;
    logic [127:0] mdl_bdata = '0;
    int           mdl_hits = 0;
    bit           pf_out = 1'b0;
    int           last_pf_lat = 1;

    function automatic logic [127:0] mdl_line(input logic [27:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
    endfunction

    task automatic drain_log();
        req_t g, e;
        while (got.size() > 0 && exp_q.size() > 0) begin
            g = got.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL mem_req: got wr=%0b addr=%h wd=%h, need wr=%0b addr=%h wd=%h",
                         g.wr, g.addr, g.wdata, e.wr, e.addr, e.wdata);
            end
        end
    endtask

    task automatic do_op(input bit wr, input logic [27:0] a, input logic [127:0] wd,
                         input int gap, input int lat, input string tag);
        bit hit;
        bit pend;
        int exp_lat;
        int n;
        logic [127:0] exp_d;
        req_t r;
        pend = pf_out;
        for (int i = 0; i <= gap; i++) begin
            @(posedge clk);
            #1;
        end
        mem_lat = lat;
        cache_addr = a;
        cache_wdata = wd;
        cache_write = wr;
        cache_read = !wr;
        exp_d = '0;
        if (wr) begin
            mdl_mem[a] = wd;
            if (mdl_valid && mdl_baddr == a) mdl_valid = 1'b0;
            r.wr = 1'b1; r.addr = a; r.wdata = wd;
            exp_q.push_back(r);
            exp_lat = (pend && gap < 8) ? -1 : lat + 1;
            pf_out = 1'b0;
        end else begin
            hit = EN && mdl_valid && mdl_baddr == a;
            if (hit) begin
                exp_d = mdl_bdata;
                mdl_valid = 1'b0;
                if (mdl_hits < 65535) mdl_hits++;
                exp_lat = (!pend || gap >= 8) ? 1 : (gap == 0 ? last_pf_lat : -1);
            end else begin
                exp_d = mdl_line(a);
                r.wr = 1'b0; r.addr = a; r.wdata = '0;
                exp_q.push_back(r);
                exp_lat = (pend && gap < 8) ? -1 : lat + 1;
            end
            if (EN) begin
                mdl_valid = 1'b1;
                mdl_baddr = a + 28'd1;
                mdl_bdata = mdl_line(mdl_baddr);
                r.wr = 1'b0; r.addr = mdl_baddr; r.wdata = '0;
                exp_q.push_back(r);
                pf_out = 1'b1;
                last_pf_lat = lat;
            end
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (cache_ready !== 1'b1 && n < 300);
        vectors++;
        if (cache_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: no cache_ready in %0d cycles, need a pulse", tag, n);
        end else begin
            if (exp_lat > 0) begin
                vectors++;
                if (n != exp_lat) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d, need %0d", tag, n, exp_lat);
                end
            end
            if (!wr) begin
                vectors++;
                if (cache_rdata !== exp_d) begin
                    miscompares++;
                    $display("FAIL %s rdata: got %h, need %h", tag, cache_rdata, exp_d);
                end
            end
            vectors++;
            if (pf_hits !== 16'(mdl_hits)) begin
                miscompares++;
                $display("FAIL %s pf_hits: got %0d, need %0d", tag, pf_hits, mdl_hits);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (cache_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse: cache_ready=%0b one cycle later, need 0", tag, cache_ready);
        end
        cache_read = 1'b0;
        cache_write = 1'b0;
        drain_log();
    endtask

    task automatic test_reset();
        proc_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({cache_ready, mem_read, mem_write, mem_addr, pf_hits} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctl: rdy=%0b rd=%0b wr=%0b addr=%h hits=%0d, need all 0",
                     cache_ready, mem_read, mem_write, mem_addr, pf_hits);
        end
        vectors++;
        if (cache_rdata !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%h wdata=%h, need 0", cache_rdata, mem_wdata);
        end
        @(posedge clk);
        #3;
        proc_reset = 1'b0;
    endtask

    task automatic test_seq_fetch();
        do_op(1'b0, 28'h0000100, '0, 0, 5, "seq_miss");
        do_op(1'b0, 28'h0000101, '0, 10, 5, "seq_hit");
    endtask

    task automatic test_early_hit();
        do_op(1'b0, 28'h0000300, '0, 10, 4, "eh_miss");
        do_op(1'b0, 28'h0000301, '0, 0, 4, "early_hit");
    endtask

    task automatic test_non_seq();
        do_op(1'b0, 28'h0000100, '0, 10, 3, "ns_fill");
        do_op(1'b0, 28'h0000200, '0, 10, 3, "non_seq");
    endtask

    task automatic test_write_inval();
        do_op(1'b0, 28'h0000100, '0, 10, 3, "wi_fill");
        do_op(1'b1, 28'h0000101, {4{32'hDEADBEEF}}, 10, 3, "wi_write");
        do_op(1'b0, 28'h0000101, '0, 10, 3, "wi_read");
        do_op(1'b0, 28'h0000180, '0, 10, 6, "wp_fill");
        do_op(1'b1, 28'h0000181, {4{32'h0BADF00D}}, 0, 2, "wr_during_pf");
        do_op(1'b0, 28'h0000181, '0, 10, 2, "stale_read");
    endtask

    task automatic test_wrap();
        do_op(1'b0, 28'hFFFFFFF, '0, 10, 2, "wrap_miss");
        do_op(1'b0, 28'h0000000, '0, 10, 2, "wrap_hit");
    endtask

    task automatic test_random();
        logic [27:0] a;
        a = 28'h0000400;
        for (int i = 0; i < 80; i++) begin
            logic [27:0] na;
            bit wr;
            int g;
            wr = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 1) == 1) na = a + 28'd1;
            else na = 28'h0000400 + 28'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: g = 0;
                1: g = 1;
                2: g = 2;
                3: g = 5;
                default: g = 9;
            endcase
            do_op(wr, na, {$urandom, $urandom, $urandom, $urandom}, g,
                  $urandom_range(1, 6), "random");
            a = na;
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] old;
        logic [27:0] a;
        req_t r;
        do_op(1'b0, 28'h0000500, '0, 10, 2, "pre_reset");
        repeat (12) @(posedge clk);
        #1;
        drain_log();
        old = mdl_baddr;
        a = old + 28'h123;
        mem_lat = 6;
        cache_addr = a;
        cache_read = 1'b1;
        r.wr = 1'b0; r.addr = a; r.wdata = '0;
        exp_q.push_back(r);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (mem_read !== 1'b1 || mem_addr !== a) begin
            miscompares++;
            $display("FAIL mid_demand: rd=%0b addr=%h, need 1 %h", mem_read, mem_addr, a);
        end
        proc_reset = 1'b1;
        #1;
        vectors++;
        if ({mem_read, mem_write, cache_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: rd=%0b wr=%0b rdy=%0b, need 000", mem_read, mem_write, cache_ready);
        end
        vectors++;
        if (pf_hits !== 16'h0) begin
            miscompares++;
            $display("FAIL async_hits: got %0d, need 0", pf_hits);
        end
        vectors++;
        if (mem_addr !== '0 || cache_rdata !== '0) begin
            miscompares++;
            $display("FAIL async_data: addr=%h rdata=%h, need 0", mem_addr, cache_rdata);
        end
        cache_read = 1'b0;
        @(posedge clk);
        #3;
        proc_reset = 1'b0;
        drain_log();
        mdl_valid = 1'b0;
        mdl_hits = 0;
        pf_out = 1'b0;
        do_op(1'b0, old, '0, 2, 3, "post_reset");
    endtask

    task automatic test_drain();
        repeat (20) @(posedge clk);
        #1;
        drain_log();
        vectors++;
        if (got.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL req_count: %0d extra issued, %0d expected not issued",
                     got.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_early_hit();
        test_non_seq();
        test_write_inval();
        test_wrap();
        test_random();
        test_reset_mid();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
